aes_kexp_seq: RTL and testbench
===============================

AES_KEXP_SEQ -- requirements
Module: aes_kexp_seq

Interface
REQ-001 The block SHALL have parameter NK, default 4, meaning key length in 32-bit words; legal values are 4, 6 and 8 (AES-128/192/256).
REQ-002 The block SHALL use derived constants NB=4, NR=NK+6 and NW=NB*(NR+1), giving 44, 52 or 60 words.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port key_in, input, 32*NK bits: cipher key; bits [32*NK-1 -: 32] are w[0] (FIPS-197 byte-string order, first byte in the MSB).
REQ-006 The block SHALL have port start, input, 1 bit: request an expansion of key_in.
REQ-007 The block SHALL have port busy, output, 1 bit: high while an expansion is in progress.
REQ-008 The block SHALL have port done, output, 1 bit: high while the word table holds a complete, valid schedule.
REQ-009 The block SHALL have port rd_addr, input, 6 bits: word index to read.
REQ-010 The block SHALL have port rd_data, output, 32 bits: registered word w[rd_addr].

Function
REQ-011 The block SHALL have FSM states IDLE, EXPAND and DONE.
- IDLE/DONE + start=1 -> EXPAND.
- EXPAND -> DONE after the word at index NW-1 is written.
REQ-012 On an accepted start, the block SHALL capture key_in into w[0..NK-1] in the same edge, set index i=NK, set Rcon=0x01, clear done and set busy.
REQ-013 In EXPAND, the block SHALL compute and write exactly one word per cycle: w[i]=w[i-NK] xor temp, where temp is derived from w[i-1] per REQ-014.
REQ-014 The block SHALL derive temp from t=w[i-1] as follows:
- i mod NK==0 -> temp=SubWord(RotWord(t)) xor {Rcon,24'h0}, then Rcon <= xtime(Rcon), i.e. shift left 1 and xor 0x1B if bit 7 was set.
- NK==8 and i mod NK==4 -> temp=SubWord(t).
- Otherwise -> temp=t.
REQ-015 SubWord SHALL apply the FIPS-197 forward S-box to each of the 4 bytes combinationally within the cycle; RotWord SHALL rotate bytes left by one ({b1,b2,b3,b0}).
REQ-016 The block SHALL compute i mod NK with a wrapping position counter (0..NK-1), not a divider.
REQ-017 busy SHALL be high for exactly NW-NK cycles (40/46/52) following the start edge; done SHALL rise on the edge that writes w[NW-1] and hold until the next accepted start or reset.
REQ-018 rd_data SHALL be w[rd_addr] registered, with 1-cycle latency; rd_addr>=NW SHALL return 32'h0.
REQ-019 Reads during EXPAND SHALL return already-written words; unwritten words return stale contents, which are undefined and need not be checked.
REQ-020 start while busy=1 SHALL be ignored, leaving the expansion unaffected; key_in changes after acceptance SHALL have no effect.
REQ-021 start in DONE SHALL restart the expansion with the new key_in, dropping done the following cycle.

Reset
REQ-022 On rst=1 the block SHALL enter IDLE with busy=0, done=0, rd_data=0, i=0 and Rcon=0x01, and clear the word table to 0.
REQ-023 The block SHALL honour rst asynchronously mid-EXPAND, leaving no partial schedule flagged valid.
REQ-024 After rst deasserts, the block SHALL accept start on the first rising edge.

Verification
REQ-025 NK=4, key 2b7e151628aed2a6abf7158809cf4f3c, start -> busy 40 cycles; w[4]=a0fafe17, w[43]=b6630ca6; done=1.
REQ-026 NK=6, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b -> busy 46 cycles; w[6]=fe0c91f7, w[51]=01002202.
REQ-027 NK=8, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 -> busy 52 cycles; w[8]=9ba35411, w[59]=706c631e (exercises the i mod 8==4 SubWord path).
REQ-028 NK=4, pulse start again at cycle 10 of busy with a different key -> ignored; the result matches REQ-025 and busy still lasts 40 cycles.
REQ-029 NK=4, assert rst at cycle 20 of EXPAND -> busy=0, done=0 and rd_data=0 immediately; a fresh start then reproduces REQ-025.
REQ-030 After DONE, sweep rd_addr 0..63 -> each word appears 1 cycle later; addresses 44..63 read 0; start in DONE with a new key -> done falls, then rises after 40 cycles with the new schedule.

Source files
------------

// File: rtl/aes_kexp_seq.sv
// Iterative AES key expansion (AES-128/192/256): one schedule word per clock,
// stored in a word table read back through a registered port.
module aes_kexp_seq #(
    parameter int NK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [32*NK-1:0] key_in,
    input  logic             start,
    output logic             busy,
    output logic             done,
    input  logic [5:0]       rd_addr,
    output logic [31:0]      rd_data
);
    localparam int NB = 4;
    localparam int NR = NK + 6;
    localparam int NW = NB * (NR + 1);

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;

    function automatic logic [31:0] sub_word(input logic [31:0] x);
        return {SBOX[x[31:24]], SBOX[x[23:16]], SBOX[x[15:8]], SBOX[x[7:0]]};
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    state_t      r_state;
    state_t      w_next;
    logic [5:0]  r_idx;
    logic [2:0]  r_pos;
    logic [7:0]  r_rcon;
    logic [31:0] r_w [NW];
    logic [31:0] r_rd_data;
    logic [31:0] w_prev;
    logic [31:0] w_back;
    logic [31:0] w_temp;
    logic [31:0] w_word;
    logic        w_accept;

    assign w_accept = start && (r_state != EXPAND);
    assign w_prev   = r_w[r_idx - 6'd1];
    assign w_back   = r_w[r_idx - 6'(NK)];
    assign w_word   = w_back ^ w_temp;
    assign busy     = (r_state == EXPAND);
    assign done     = (r_state == DONE);
    assign rd_data  = r_rd_data;

    // r_pos tracks i mod NK so no divider is needed.
    always_comb begin
        w_temp = w_prev;
        if (r_pos == 3'd0)
            w_temp = sub_word({w_prev[23:0], w_prev[31:24]}) ^ {r_rcon, 24'h0};
        else if (NK == 8 && r_pos == 3'd4)
            w_temp = sub_word(w_prev);
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE, DONE: if (start) w_next = EXPAND;
            EXPAND:     if (r_idx == 6'(NW - 1)) w_next = DONE;
            default:    w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx  <= 6'd0;
            r_pos  <= 3'd0;
            r_rcon <= 8'h01;
            for (int k = 0; k < NW; k++) r_w[k] <= 32'h0;
        end else if (w_accept) begin
            for (int k = 0; k < NK; k++) r_w[k] <= key_in[32*(NK-k)-1 -: 32];
            r_idx  <= 6'(NK);
            r_pos  <= 3'd0;
            r_rcon <= 8'h01;
        end else if (r_state == EXPAND) begin
            r_w[r_idx] <= w_word;
            r_idx      <= r_idx + 6'd1;
            r_pos      <= (r_pos == 3'(NK - 1)) ? 3'd0 : r_pos + 3'd1;
            if (r_pos == 3'd0) r_rcon <= xtime(r_rcon);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_rd_data <= 32'h0;
        else     r_rd_data <= (rd_addr < 6'(NW)) ? r_w[rd_addr] : 32'h0;
    end
endmodule

// File: tb/tb_aes_kexp_seq.sv
// Bench for aes_kexp_seq: three instances (NK=4/6/8) against a FIPS-197 model
// whose S-box is derived from GF(2^8) inversion plus the affine map.
module tb_aes_kexp_seq;
    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [5:0]   rd_addr;
    logic [255:0] kk [3];
    logic [127:0] key4;
    logic [191:0] key6;
    logic [255:0] key8;
    logic         busy4, busy6, busy8, done4, done6, done8;
    logic [31:0]  rd4, rd6, rd8;

    int           total = 0;
    int           bad = 0;
    logic [7:0]   sb [256];
    logic [31:0]  mdl [3][60];
    int           nks [3] = '{4, 6, 8};

    typedef struct {
        int          s;
        int          addr;
        logic [31:0] exp;
    } kat_t;
    kat_t kat [8];

    always #5 clk = ~clk;

    assign key4 = kk[0][255:128];
    assign key6 = kk[1][255:64];
    assign key8 = kk[2];

    aes_kexp_seq #(.NK(4)) dut4 (.clk(clk), .rst(rst), .key_in(key4), .start(start),
        .busy(busy4), .done(done4), .rd_addr(rd_addr), .rd_data(rd4));
    aes_kexp_seq #(.NK(6)) dut6 (.clk(clk), .rst(rst), .key_in(key6), .start(start),
        .busy(busy6), .done(done6), .rd_addr(rd_addr), .rd_data(rd6));
    aes_kexp_seq #(.NK(8)) dut8 (.clk(clk), .rst(rst), .key_in(key8), .start(start),
        .busy(busy8), .done(done8), .rd_addr(rd_addr), .rd_data(rd8));

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa, bb;
        p = 8'h00; aa = a; bb = b;
        for (int k = 0; k < 8; k++) begin
            if (bb[0]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h01;
            if (x == 0) inv = 8'h00;
            else for (int e = 0; e < 254; e++) inv = gmul(inv, 8'(x));
            sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] subw(input logic [31:0] x);
        return {sb[x[31:24]], sb[x[23:16]], sb[x[15:8]], sb[x[7:0]]};
    endfunction

    task automatic compute(input int s);
        int nk, nw;
        logic [31:0] t;
        logic [7:0]  rc;
        nk = nks[s];
        nw = 4 * (nk + 7);
        for (int i = 0; i < 60; i++) mdl[s][i] = 32'h0;
        for (int i = 0; i < nk; i++) mdl[s][i] = kk[s][255 - 32*i -: 32];
        rc = 8'h01;
        for (int i = nk; i < nw; i++) begin
            t = mdl[s][i-1];
            if (i % nk == 0) begin
                t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end else if (nk > 6 && i % nk == 4) begin
                t = subw(t);
            end
            mdl[s][i] = mdl[s][i-nk] ^ t;
        end
    endtask

    function automatic logic [255:0] rnd256();
        return {$urandom(), $urandom(), $urandom(), $urandom(),
                $urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    function automatic logic [31:0] rdv(input int s);
        return (s == 0) ? rd4 : (s == 1) ? rd6 : rd8;
    endfunction
    function automatic logic [31:0] bsy(input int s);
        return {31'b0, (s == 0) ? busy4 : (s == 1) ? busy6 : busy8};
    endfunction
    function automatic logic [31:0] dn(input int s);
        return {31'b0, (s == 0) ? done4 : (s == 1) ? done6 : done8};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic set_fips();
        kk[0] = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
        kk[1] = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
        kk[2] = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    endtask

    // Called at a falling edge: start is seen on the very next rising edge.
    task automatic run(input int glitch_at);
        int c [3];
        c = '{0, 0, 0};
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int s = 0; s < 3; s++) begin
            chk($sformatf("busy_after_start nk=%0d", nks[s]), bsy(s), 32'd1);
            chk($sformatf("done_after_start nk=%0d", nks[s]), dn(s), 32'd0);
        end
        for (int n = 1; n <= 80; n++) begin
            for (int s = 0; s < 3; s++) if (bsy(s) == 32'd1) c[s]++;
            if (n == glitch_at) begin
                start = 1'b1;
                for (int s = 0; s < 3; s++) kk[s] = rnd256();
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        for (int s = 0; s < 3; s++) begin
            chk($sformatf("busy_cycles nk=%0d", nks[s]), 32'(c[s]), 32'(4*(nks[s]+7) - nks[s]));
            chk($sformatf("done_end nk=%0d", nks[s]), dn(s), 32'd1);
            chk($sformatf("busy_end nk=%0d", nks[s]), bsy(s), 32'd0);
        end
    endtask

    task automatic sweep(input string tag);
        for (int a = 0; a < 64; a++) begin
            @(negedge clk);
            rd_addr = 6'(a);
            @(posedge clk);
            #1;
            for (int s = 0; s < 3; s++)
                chk($sformatf("%s nk=%0d w[%0d]", tag, nks[s], a), rdv(s),
                    (a < 60) ? mdl[s][a] : 32'h0);
        end
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        rd_addr = 6'd0;
        set_fips();
        build_sbox();
        kat[0] = '{0, 0, 32'h2b7e1516};
        kat[1] = '{0, 4, 32'ha0fafe17};
        kat[2] = '{0, 43, 32'hb6630ca6};
        kat[3] = '{1, 6, 32'hfe0c91f7};
        kat[4] = '{1, 51, 32'h01002202};
        kat[5] = '{2, 8, 32'h9ba35411};
        kat[6] = '{2, 59, 32'h706c631e};
        kat[7] = '{2, 0, 32'h603deb10};

        repeat (3) @(posedge clk);
        #1;
        for (int s = 0; s < 3; s++) begin
            chk($sformatf("reset_busy nk=%0d", nks[s]), bsy(s), 32'd0);
            chk($sformatf("reset_done nk=%0d", nks[s]), dn(s), 32'd0);
            chk($sformatf("reset_rd nk=%0d", nks[s]), rdv(s), 32'd0);
        end

        // FIPS-197 vectors, start on the first edge after reset release
        for (int s = 0; s < 3; s++) compute(s);
        @(negedge clk);
        rst = 1'b0;
        run(0);
        sweep("fips");
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            rd_addr = 6'(kat[k].addr);
            @(posedge clk);
            #1;
            chk($sformatf("kat nk=%0d w[%0d]", nks[kat[k].s], kat[k].addr), rdv(kat[k].s), kat[k].exp);
        end

        // restart from DONE with a second start and key change mid-expansion
        set_fips();
        @(negedge clk);
        run(10);
        sweep("glitch");

        // asynchronous reset in the middle of an expansion
        for (int s = 0; s < 3; s++) kk[s] = rnd256();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        for (int s = 0; s < 3; s++) begin
            chk($sformatf("midrst_busy nk=%0d", nks[s]), bsy(s), 32'd0);
            chk($sformatf("midrst_done nk=%0d", nks[s]), dn(s), 32'd0);
            chk($sformatf("midrst_rd nk=%0d", nks[s]), rdv(s), 32'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int s = 0; s < 3; s++)
            for (int i = 0; i < 60; i++) mdl[s][i] = 32'h0;
        sweep("cleared");
        for (int s = 0; s < 3; s++)
            chk($sformatf("cleared_done nk=%0d", nks[s]), dn(s), 32'd0);
        set_fips();
        for (int s = 0; s < 3; s++) compute(s);
        @(negedge clk);
        run(0);
        sweep("after_rst");

        // random keys, each restarted from DONE
        for (int r = 0; r < 3; r++) begin
            for (int s = 0; s < 3; s++) begin
                kk[s] = rnd256();
                compute(s);
            end
            @(negedge clk);
            run(0);
            sweep($sformatf("rand%0d", r));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
